// File: rtl/mpc_decomp_pkg.sv
// rtl/mpc_decomp_pkg.sv - MPC pattern codes and code-width helper shared by compressor and decompressor
package mpc_decomp_pkg;

  localparam int unsigned PAT_RAW        = 0;
  localparam int unsigned PAT_ZERO       = 1;
  localparam int unsigned PAT_REP_WORD   = 2;
  localparam int unsigned PAT_REP_DWORD  = 3;
  localparam int unsigned PAT_DELTA8     = 4;
  localparam int unsigned PAT_DELTA16    = 5;
  localparam int unsigned PAT_HALF_ZERO  = 6;
  localparam int unsigned PAT_FIRST_RSVD = 7;

  function automatic int len_encode(input int num_patterns);
    return (num_patterns > 1) ? $clog2(num_patterns) : 1;
  endfunction

endpackage

// File: rtl/mpc_line_fifo.sv
// rtl/mpc_line_fifo.sv - first-word fall-through register FIFO with exposed occupancy count
module mpc_line_fifo #(
  parameter int WIDTH = 257,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = push_i & (r_count != CW'(DEPTH));
  assign w_pop   = pop_i & (r_count != '0);
  assign valid_o = (r_count != '0);
  assign count_o = r_count;
  // Empty head reads as zero so the line outputs idle at their reset value.
  assign head_o  = valid_o ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/mpc_decompressor_stream.sv
// rtl/mpc_decompressor_stream.sv - streaming MPC line decompressor with decode register, output FIFO and counters
module mpc_decompressor_stream
  import mpc_decomp_pkg::*;
#(
  parameter int LINE_BITS    = 256,
  parameter int WORD_BITS    = 32,
  parameter int NUM_PATTERNS = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [LINE_BITS+len_encode(NUM_PATTERNS)-1:0] data_i,
  input  logic                                         valid_i,
  output logic                                         ready_o,
  input  logic                                         flush_i,
  output logic [LINE_BITS-1:0]                         data_o,
  output logic                                         valid_o,
  output logic                                         err_o,
  input  logic                                         ready_i,
  output logic [31:0]                                  line_cnt_o,
  output logic [15:0]                                  err_cnt_o
);

  localparam int LEN_ENCODE = len_encode(NUM_PATTERNS);
  localparam int N_WORDS    = LINE_BITS / WORD_BITS;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  // Returns {err, line}; reserved codes decode to an all-zero line with err set.
  function automatic logic [LINE_BITS:0] decode(input logic [LEN_ENCODE-1:0] code,
                                                input logic [LINE_BITS-1:0]  p);
    logic [LINE_BITS-1:0] out;
    logic                 err;
    logic [WORD_BITS-1:0] b;
    logic [7:0]           d8;
    logic [15:0]          d16;
    int unsigned          c;
    out = '0;
    err = 1'b0;
    b   = p[WORD_BITS-1:0];
    c   = 32'(code);
    case (c)
      PAT_RAW:       out = p;
      PAT_ZERO:      out = '0;
      PAT_REP_WORD:  for (int i = 0; i < N_WORDS; i++) out[i*WORD_BITS +: WORD_BITS] = b;
      PAT_REP_DWORD: for (int i = 0; i < N_WORDS/2; i++)
                       out[i*2*WORD_BITS +: 2*WORD_BITS] = p[2*WORD_BITS-1:0];
      PAT_DELTA8:    for (int i = 0; i < N_WORDS; i++) begin
                       d8 = p[WORD_BITS+8*i +: 8];
                       out[i*WORD_BITS +: WORD_BITS] = b + {{(WORD_BITS-8){d8[7]}}, d8};
                     end
      PAT_DELTA16:   for (int i = 0; i < N_WORDS; i++) begin
                       d16 = p[WORD_BITS+16*i +: 16];
                       out[i*WORD_BITS +: WORD_BITS] = b + {{(WORD_BITS-16){d16[15]}}, d16};
                     end
      PAT_HALF_ZERO: out[LINE_BITS/2-1:0] = p[LINE_BITS/2-1:0];
      default:       err = 1'b1;
    endcase
    return {err, out};
  endfunction

  logic [LINE_BITS-1:0] r_s1_data;
  logic                 r_s1_err;
  logic                 r_s1_valid;
  logic [31:0]          r_line_cnt;
  logic [15:0]          r_err_cnt;
  logic [LINE_BITS:0]   w_dec;
  logic                 w_accept;
  logic [CW-1:0]        w_fifo_count;
  logic [CW:0]          w_occ;

  assign w_dec    = decode(data_i[LINE_BITS +: LEN_ENCODE], data_i[LINE_BITS-1:0]);
  // S1 holds a credit so its line always has a FIFO slot on the next edge.
  assign w_occ    = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_s1_valid};
  assign ready_o  = (w_occ < (CW+1)'(FIFO_DEPTH));
  assign w_accept = valid_i & ready_o & ~flush_i;

  assign line_cnt_o = r_line_cnt;
  assign err_cnt_o  = r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_data  <= '0;
      r_s1_err   <= 1'b0;
      r_s1_valid <= 1'b0;
      r_line_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_data  <= w_dec[LINE_BITS-1:0];
        r_s1_err   <= w_dec[LINE_BITS];
        r_line_cnt <= r_line_cnt + 32'd1;
        if (w_dec[LINE_BITS] && (r_err_cnt != 16'hFFFF)) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
      end
    end
  end

  mpc_line_fifo #(
    .WIDTH (LINE_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .push_i      (r_s1_valid & ~flush_i),
    .push_data_i ({r_s1_err, r_s1_data}),
    .pop_i       (valid_o & ready_i),
    .head_o      ({err_o, data_o}),
    .valid_o     (valid_o),
    .count_o     (w_fifo_count)
  );

endmodule
